// File: rtl/reg_file_v.sv
// Vector/scalar register file: REGNUM x VECTOR_WIDTH lanes of WIDTH bits, 2 vector + 2 scalar read ports, 1 write port.
// Optional same-cycle write forwarding on the read ports: define REGFILE_V_BYPASS_EN.

module reg_file_v_lane #(
  parameter int WIDTH        = 24,
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDRESSWIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [ADDRESSWIDTH-1:0] rd_addr1,
  input  logic [ADDRESSWIDTH-1:0] rd_addr2,
  output logic [WIDTH-1:0]        rd_data1,
  output logic [WIDTH-1:0]        rd_data2
);
  localparam logic [ADDRESSWIDTH:0] NREG = (ADDRESSWIDTH+1)'(REGNUM);

  logic [REGNUM-1:0][WIDTH-1:0] regs;
  logic rd_ok1, rd_ok2, fwd1, fwd2;

  // wr_en already folds in address range and lane selection
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        regs          <= '0;
    else if (wr_en) regs[wr_addr] <= wr_data;
  end

  assign rd_ok1 = {1'b0, rd_addr1} < NREG;
  assign rd_ok2 = {1'b0, rd_addr2} < NREG;

`ifdef REGFILE_V_BYPASS_EN
  assign fwd1 = wr_en && (rd_addr1 == wr_addr);
  assign fwd2 = wr_en && (rd_addr2 == wr_addr);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign rd_data1 = !rd_ok1 ? '0 : fwd1 ? wr_data : regs[rd_addr1];
  assign rd_data2 = !rd_ok2 ? '0 : fwd2 ? wr_data : regs[rd_addr2];
endmodule

module reg_file_v #(
  parameter int WIDTH        = 24,
  parameter int REGNUM       = 16,
  parameter int VECTOR_WIDTH = 8,
  parameter int ADDRESSWIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                we,
  input  logic [ADDRESSWIDTH-1:0]             reg_num,
  input  logic [ADDRESSWIDTH-1:0]             reg_num2,
  input  logic [ADDRESSWIDTH-1:0]             wd3,
  input  logic [2:0]                          index,
  input  logic [2:0]                          index_A,
  input  logic [WIDTH-1:0]                    data_in,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  data_in_v,
  input  logic [WIDTH-1:0]                    PC,
  input  logic                                isvector,
  input  logic                                vect_esc,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  data_out,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  data_out2,
  output logic [WIDTH-1:0]                    data_out_s,
  output logic [WIDTH-1:0]                    data_out_s2
);
  localparam logic [ADDRESSWIDTH:0]   NREG    = (ADDRESSWIDTH+1)'(REGNUM);
  localparam logic [ADDRESSWIDTH-1:0] PC_ADDR = ADDRESSWIDTH'(REGNUM-1);

  logic       wr_ok, full_vec;
  logic [2:0] sel;
  logic [VECTOR_WIDTH-1:0] lane_we;

  assign wr_ok    = we && ({1'b0, wd3} < NREG);
  assign full_vec = isvector && !vect_esc;

  for (genvar l = 0; l < VECTOR_WIDTH; l++) begin : g_lane
    // scalar mode always targets lane 0
    assign lane_we[l] = wr_ok && (full_vec ||
                                  ( isvector && (index_A == 3'(l))) ||
                                  (!isvector && (l == 0)));

    reg_file_v_lane #(
      .WIDTH        (WIDTH),
      .REGNUM       (REGNUM),
      .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (lane_we[l]),
      .wr_addr  (wd3),
      .wr_data  (full_vec ? data_in_v[l] : data_in),
      .rd_addr1 (reg_num),
      .rd_addr2 (reg_num2),
      .rd_data1 (data_out[l]),
      .rd_data2 (data_out2[l])
    );
  end

  // top register reads as PC only on scalar-mode scalar reads
  assign sel         = isvector ? index : 3'd0;
  assign data_out_s  = (!isvector && reg_num  == PC_ADDR) ? PC : data_out[sel];
  assign data_out_s2 = (!isvector && reg_num2 == PC_ADDR) ? PC : data_out2[sel];
endmodule

// File: tb/tb_reg_file_v.sv
// Directed + randomized checks of reg_file_v against an array-based reference model.
module tb_reg_file_v;
  typedef logic [7:0][23:0] vec_t;

  logic        clk = 1'b0;
  logic        rst, we, isvector, vect_esc;
  logic [3:0]  reg_num, reg_num2, wd3;
  logic [2:0]  index, index_A;
  logic [23:0] data_in, PC;
  vec_t        data_in_v, data_out, data_out2;
  logic [23:0] data_out_s, data_out_s2;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  vec_t model [16];

  always #5 clk = ~clk;

  reg_file_v dut (
    .clk(clk), .rst(rst), .we(we), .reg_num(reg_num), .reg_num2(reg_num2), .wd3(wd3),
    .index(index), .index_A(index_A), .data_in(data_in), .data_in_v(data_in_v), .PC(PC),
    .isvector(isvector), .vect_esc(vect_esc), .data_out(data_out), .data_out2(data_out2),
    .data_out_s(data_out_s), .data_out_s2(data_out_s2)
  );

  // register contents after the currently presented write lands
  function automatic vec_t written(vec_t cur);
    vec_t r = cur;
    if (isvector && !vect_esc) r = data_in_v;
    else if (isvector)         r[index_A] = data_in;
    else                       r[0] = data_in;
    return r;
  endfunction

  function automatic vec_t exp_vec(logic [3:0] a);
    vec_t r = model[a];
`ifdef REGFILE_V_BYPASS_EN
    if (we && !rst && a == wd3) r = written(model[a]);
`endif
    return r;
  endfunction

  function automatic logic [23:0] exp_s(logic [3:0] a);
    vec_t r = exp_vec(a);
    if (!isvector && a == 4'd15) return PC;
    return isvector ? r[index] : r[0];
  endfunction

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".vec1"}, data_out,    exp_vec(reg_num));
    chk({tag, ".vec2"}, data_out2,   exp_vec(reg_num2));
    chk({tag, ".s1"},   data_out_s,  exp_s(reg_num));
    chk({tag, ".s2"},   data_out_s2, exp_s(reg_num2));
  endtask

  task automatic tick();
    if (rst)     foreach (model[i]) model[i] = '0;
    else if (we) model[wd3] = written(model[wd3]);
    @(posedge clk); #1;
  endtask

  task automatic rand_vec(output vec_t v);
    for (int l = 0; l < 8; l++) v[l] = 24'($urandom);
  endtask

  initial begin
    vec_t v56;
    for (int l = 0; l < 8; l++) v56[l] = 24'h000056;
    foreach (model[i]) model[i] = '0;
    rst = 1; we = 0; isvector = 1; vect_esc = 0; reg_num = 0; reg_num2 = 0; wd3 = 0;
    index = 0; index_A = 0; data_in = 0; data_in_v = '0; PC = 24'hABCDEF;
    #2;
    // reset state, every address
    for (int a = 0; a < 16; a++) begin
      reg_num = 4'(a); reg_num2 = 4'(15 - a); #1;
      chk("rst.vec", data_out, '0);
      chk("rst.s",   data_out_s, '0);
    end
    isvector = 0; reg_num = 4'd3; reg_num2 = 4'd15; #1;
    chk("rst.pc_s2", data_out_s2, 24'hABCDEF);
    chk("rst.s1",    data_out_s,  '0);
    @(negedge clk); rst = 0;

    // full-vector write
    we = 1; isvector = 1; vect_esc = 0; wd3 = 2; data_in_v = v56;
    tick();
    we = 0; reg_num = 2; #1;
    chk("fullvec", data_out, v56);
    check_all("fullvec");

    // single-lane write
    we = 1; vect_esc = 1; wd3 = 3; index_A = 2; data_in = 24'h000001;
    tick();
    we = 0; reg_num = 3; index = 2; #1;
    chk("lane.idx2", data_out_s, 24'h000001);
    index = 3; #1;
    chk("lane.idx3", data_out_s, 24'h000000);
    chk("lane.vec",  data_out,   {24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h000001, 24'h0, 24'h0});

    // we=0 hold
    for (int i = 0; i < 4; i++) begin
      wd3 = 4'($urandom); data_in = 24'($urandom); rand_vec(data_in_v);
      isvector = 1'($urandom); vect_esc = 1'($urandom);
      tick();
    end
    isvector = 1; reg_num = 2; #1;
    chk("hold.reg2", data_out, v56);
    check_all("hold");

    // scalar mode write + PC mapping
    isvector = 0; we = 1; wd3 = 5; data_in = 24'h123456;
    tick();
    we = 0; reg_num = 5; reg_num2 = 15; #1;
    chk("scalar.s1",  data_out_s,  24'h123456);
    chk("scalar.hi",  data_out[7:1], '0);
    chk("scalar.pc",  data_out_s2, 24'hABCDEF);

    // same-cycle read/write of reg 2 lane 2
    isvector = 1; vect_esc = 1; we = 1; wd3 = 2; index_A = 2; index = 2;
    data_in = 24'h0000AA; reg_num = 2; #1;
`ifdef REGFILE_V_BYPASS_EN
    chk("rw.pre", data_out_s, 24'h0000AA);
`else
    chk("rw.pre", data_out_s, 24'h000056);
`endif
    check_all("rw.pre");
    tick();
    we = 0; #1;
    chk("rw.post", data_out_s, 24'h0000AA);

    // PC register is writable and reads back in vector mode
    isvector = 0; we = 1; wd3 = 15; data_in = 24'h777777;
    tick();
    we = 0; isvector = 1; index = 0; reg_num = 15; #1;
    chk("r15.store", data_out_s, 24'h777777);

    // randomized traffic, occasional async reset
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 3) != 0); isvector = 1'($urandom); vect_esc = 1'($urandom);
      wd3 = 4'($urandom); reg_num = 4'($urandom); reg_num2 = 4'($urandom);
      if ($urandom_range(0, 2) == 0) reg_num = wd3;
      index = 3'($urandom); index_A = 3'($urandom);
      data_in = 24'($urandom); rand_vec(data_in_v); PC = 24'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1; #1;
        foreach (model[k]) model[k] = '0;
        check_all("rnd.rst");
        tick();
        check_all("rnd.rst_edge");
        rst = 0;
      end
      #1;
      check_all("rnd.pre");
      tick();
    end
    we = 0; #1;
    check_all("rnd.end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_file_v.md
# reg_file_v

Vector/scalar register file for the vector processor datapath: REGNUM registers, each holding VECTOR_WIDTH lanes of WIDTH bits. Provides two combinational vector read ports, two combinational scalar (single-lane) read ports, and one synchronous write port. The write port can write either a whole vector or a single lane. Sits between decode and execute; the scalar path maps the top register to the program counter.

## Interface
Parameters:
- WIDTH, 24, lane/scalar data width in bits
- REGNUM, 16, number of registers
- VECTOR_WIDTH, 8, lanes per register
- ADDRESSWIDTH, 4, register address width (2^ADDRESSWIDTH ≥ REGNUM)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all writes occur on its rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable
- reg_num  in  ADDRESSWIDTH  read address, port 1
- reg_num2  in  ADDRESSWIDTH  read address, port 2
- wd3  in  ADDRESSWIDTH  write address
- index  in  3  lane selected for the scalar reads
- index_A  in  3  lane written by a single-lane write
- data_in  in  WIDTH  scalar/lane write data
- data_in_v  in  VECTOR_WIDTH×WIDTH  full-vector write data; lane i is at bits [i*WIDTH +: WIDTH]
- PC  in  WIDTH  current program counter
- isvector  in  1  1 = vector-mode access; 0 = scalar-mode access
- vect_esc  in  1  when isvector=1: 0 = full-vector write, 1 = single-lane write
- data_out  out  VECTOR_WIDTH×WIDTH  all lanes of reg_num
- data_out2  out  VECTOR_WIDTH×WIDTH  all lanes of reg_num2
- data_out_s  out  WIDTH  scalar read, port 1
- data_out_s2  out  WIDTH  scalar read, port 2

## Operation
- Storage is REGNUM × VECTOR_WIDTH lanes of WIDTH bits.
- Write, when we=1, by mode:
  - isvector=1, vect_esc=0: every lane of register wd3 ← data_in_v.
  - isvector=1, vect_esc=1: only lane index_A of register wd3 ← data_in; all other lanes unchanged.
  - isvector=0: lane 0 of register wd3 ← data_in; lanes 1..7 unchanged.
- we=0: no state change, regardless of the other inputs.
- Vector reads: data_out = reg[reg_num]; data_out2 = reg[reg_num2]. Reads are combinational.
- Scalar read lane selection:
  - isvector=1: data_out_s = reg[reg_num][index]; data_out_s2 = reg[reg_num2][index].
  - isvector=0: lane 0 of each addressed register is read.
- PC mapping: with isvector=0, a scalar read whose address equals REGNUM-1 returns PC instead of the stored lane.
  - This override never applies to vector reads or to vector-mode scalar reads.
- Register REGNUM-1 is otherwise ordinary storage and is writable in every mode.
- Addresses ≥ REGNUM:
  - writes are ignored;
  - reads return 0.
- index and index_A always address a valid lane (VECTOR_WIDTH = 8).

## Timing
- rst=1 clears every lane of every register to 0 immediately, without waiting for a clock edge.
  - Outputs then show 0, except data_out_s/data_out_s2, which show PC when the PC mapping applies.
- Reset has priority over a write on the same edge. Writes resume on the first rising edge after rst deasserts.
- Write latency: data is stored at the rising edge; read ports show it in the same cycle, immediately after that edge.
- Read latency: zero cycles (purely combinational from address/index/mode inputs).
- Read and write of the same register in one cycle: reads return the pre-edge contents (unless REGFILE_V_BYPASS_EN is defined).
- Single write port: no write conflicts are possible.

## Configuration
- REGFILE_V_BYPASS_EN defined:
  - Read ports forward the pending write combinationally when we=1 and the read address equals wd3.
  - Forwarding is per lane: only lanes that the current write mode will modify are forwarded; the other lanes come from storage.
  - The PC mapping still takes precedence for scalar reads.
- REGFILE_V_BYPASS_EN not defined: no forwarding; reads always reflect stored contents.

## Test plan
- Reset: assert rst with clk idle → every data_out lane and data_out_s read as 0 for all addresses; register 15 scalar read with isvector=0 returns PC=0xABCDEF.
- Full-vector write:
  - Stimulus: we=1, isvector=1, vect_esc=0, wd3=2, data_in_v all lanes 0x000056, then one edge.
  - Response: reg_num=2 gives data_out = 8×0x000056.
- Lane write:
  - Stimulus: we=1, isvector=1, vect_esc=1, wd3=3, index_A=2, data_in=0x000001, then one edge.
  - Response: reg 3 lane 2 = 0x000001, other lanes 0. With we=0, reg_num=3, index=2 → data_out_s=0x000001; index=3 → 0.
- we=0 hold: change wd3/data_in/data_in_v across several edges with we=0 → all registers unchanged; data_out for reg 2 stays 8×0x000056.
- Scalar mode:
  - Stimulus: isvector=0, we=1, wd3=5, data_in=0x123456, then one edge.
  - Response: reg_num=5 → data_out_s=0x123456, and data_out lanes 1..7 = 0. reg_num2=15 → data_out_s2=PC (0xABCDEF).
- Same-cycle read/write of reg 2 lane 2 with data_in=0x0000AA:
  - before the edge, data_out_s shows the old value 0x000056 (0x0000AA with REGFILE_V_BYPASS_EN);
  - after the edge, 0x0000AA in both builds.
